// File: rtl/calc_op_sequencer.sv
// Sequences one shared W-bit adder through ADD, SUB and shift-add MUL requests.
// Operands are latched on an accepted start; the 2W-bit result is returned with a done pulse.
module calc_op_sequencer #(
  parameter int unsigned W       = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [W-1:0]     opa,
  input  logic [W-1:0]     opb,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   result,
  output logic             ovf,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_cin,
  input  logic [W-1:0]     add_s,
  input  logic             add_cout
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpRes = 2'b11;

  localparam int unsigned IW = (W > 2) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LastIter = IW'(W - 1);
  localparam logic [1:0] LastLat = 2'(ADD_LAT);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q;
  logic [2*W-1:0]   p_q;
  logic [1:0]       lat_q;
  logic [IW-1:0]    iter_q;
  logic [2*W-1:0]   p_nxt;

  // Product register after absorbing one adder capture: shift right with carry-in at the top.
  assign p_nxt = {add_cout, add_s, p_q[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      p_q     <= '0;
      lat_q   <= '0;
      iter_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            state_q <= StExec;
            busy    <= 1'b1;
            op_q    <= op;
            a_q     <= opa;
            p_q     <= {{W{1'b0}}, opb};
            lat_q   <= '0;
            iter_q  <= '0;
            case (op)
              OpAdd: begin
                add_a   <= opa;
                add_b   <= opb;
                add_cin <= 1'b0;
              end
              OpSub: begin
                add_a   <= opa;
                add_b   <= ~opb;
                add_cin <= 1'b1;
              end
              OpMul: begin
                add_a   <= '0;
                add_b   <= opb[0] ? opa : '0;
                add_cin <= 1'b0;
              end
              default: begin
                add_a   <= '0;
                add_b   <= '0;
                add_cin <= 1'b0;
              end
            endcase
          end else begin
            state_q <= StIdle;
          end
        end
        StExec: begin
          if (op_q == OpRes) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= '0;
            ovf     <= 1'b1;
          end else if (lat_q != LastLat) begin
            lat_q <= lat_q + 2'd1;
          end else begin
            // Last edge of the adder window: add_s/add_cout are valid now.
            lat_q <= '0;
            if (op_q == OpMul && iter_q != LastIter) begin
              p_q    <= p_nxt;
              iter_q <= iter_q + 1'b1;
              add_a  <= p_nxt[2*W-1:W];
              add_b  <= p_nxt[0] ? a_q : '0;
            end else begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              add_a   <= '0;
              add_b   <= '0;
              add_cin <= 1'b0;
              case (op_q)
                OpAdd: begin
                  result <= {{(W-1){1'b0}}, add_cout, add_s};
                  ovf    <= 1'b0;
                end
                OpSub: begin
                  result <= {{W{1'b0}}, add_s};
                  ovf    <= ~add_cout;
                end
                default: begin
                  p_q    <= p_nxt;
                  result <= p_nxt;
                  ovf    <= 1'b0;
                end
              endcase
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Runs three sequencers (ADD_LAT = 0, 1, 2) side by side on shared stimulus, each with its own
// latency-accurate adder, against a cycle-level behavioural model plus literal expectations.
module tb_calc_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] opa = 4'd0;
  logic [3:0] opb = 4'd0;

  logic [2:0]       busy_v, done_v, ovf_v, add_cin_v, add_cout_v;
  logic [2:0][7:0]  result_v;
  logic [2:0][3:0]  add_a_v, add_b_v, add_s_v;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [4:0] sc, p1, p2;
    assign sc = {1'b0, add_a_v[g]} + {1'b0, add_b_v[g]} + {4'b0, add_cin_v[g]};
    always @(posedge clk) begin
      p1 <= sc;
      p2 <= p1;
    end
    assign {add_cout_v[g], add_s_v[g]} = (g == 0) ? sc : (g == 1) ? p1 : p2;

    calc_op_sequencer #(.W(4), .ADD_LAT(g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .opa      (opa),
      .opb      (opb),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .result   (result_v[g]),
      .ovf      (ovf_v[g]),
      .add_a    (add_a_v[g]),
      .add_b    (add_b_v[g]),
      .add_cin  (add_cin_v[g]),
      .add_s    (add_s_v[g]),
      .add_cout (add_cout_v[g])
    );
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lat%0d: got %0h expected %0h (t=%0t)", nm, g, act, exp, $time);
    end
  endtask

  // Number of cycles spent executing, from the operation's arithmetic.
  function automatic int exec_len(input logic [1:0] o, input int l);
    case (o)
      2'b00, 2'b01: return 1 + l;
      2'b10:        return 4 * (1 + l);
      default:      return 1;
    endcase
  endfunction

  // Expected {ovf, result} from plain arithmetic.
  function automatic logic [8:0] golden(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    int s;
    case (o)
      2'b00: begin s = int'(a) + int'(b); return {1'b0, 8'(s)}; end
      2'b01: begin s = (int'(a) - int'(b)) & 15; return {(a < b), 8'(s)}; end
      2'b10: begin s = int'(a) * int'(b); return {1'b0, 8'(s)}; end
      default: return 9'h100;
    endcase
  endfunction

  // Cycle model: phase 0 idle, 1 executing, 2 done.
  int         ph [3] = '{0, 0, 0};
  int         left [3];
  logic [7:0] er [3] = '{8'd0, 8'd0, 8'd0};
  logic       eo [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] pend [3];
  logic [1:0] pop [3];
  logic [3:0] pa [3], pb [3];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (chk_en) begin
        chk("busy", g, 32'(busy_v[g]), 32'(ph[g] == 1));
        chk("done", g, 32'(done_v[g]), 32'(ph[g] == 2));
        chk("result", g, 32'(result_v[g]), 32'(er[g]));
        chk("ovf", g, 32'(ovf_v[g]), 32'(eo[g]));
        if (ph[g] != 1) begin
          chk("adder_idle", g, {add_a_v[g], add_b_v[g], 3'b0, add_cin_v[g]}, 32'd0);
        end else if (pop[g] == 2'b00) begin
          chk("add_opnds", g, {add_a_v[g], add_b_v[g], 3'b0, add_cin_v[g]}, {pa[g], pb[g], 4'd0});
        end else if (pop[g] == 2'b01) begin
          chk("sub_opnds", g, {add_a_v[g], add_b_v[g], 3'b0, add_cin_v[g]}, {pa[g], ~pb[g], 4'd1});
        end
      end
      if (rst) begin
        ph[g] = 0; er[g] = 8'd0; eo[g] = 1'b0;
      end else if (start && ph[g] != 1) begin
        ph[g] = 1; left[g] = exec_len(op, g); pend[g] = golden(op, opa, opb);
        pop[g] = op; pa[g] = opa; pb[g] = opb;
      end else if (ph[g] == 1) begin
        left[g]--;
        if (left[g] == 0) begin
          ph[g] = 2; er[g] = pend[g][7:0]; eo[g] = pend[g][8];
        end
      end else if (ph[g] == 2) begin
        ph[g] = 0;
      end
    end
  end

  // One operation with hand-computed expectations; optionally pokes start while busy.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] xr, input logic xo,
                        input int xlat0, input int xlat1, input int xlat2, input bit poke);
    int lat [3];
    int xl [3];
    bit seen [3];
    int cyc;
    xl[0] = xlat0; xl[1] = xlat1; xl[2] = xlat2;
    for (int g = 0; g < 3; g++) begin seen[g] = 1'b0; lat[g] = -1; end
    @(posedge clk); #1;
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 200) begin
      if (poke && cyc == 1) begin start = 1'b1; op = 2'b00; opa = ~a; opb = 4'd1; end
      if (poke && cyc == 2) start = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && done_v[g]) begin
          seen[g] = 1'b1;
          lat[g] = cyc;
          chk({nm, "_result"}, g, 32'(result_v[g]), 32'(xr));
          chk({nm, "_ovf"}, g, 32'(ovf_v[g]), 32'(xo));
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    for (int g = 0; g < 3; g++) chk({nm, "_latency"}, g, lat[g], xl[g]);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int g = 0; g < 3; g++) begin
      chk("reset_state", g, {busy_v[g], done_v[g], ovf_v[g], add_cin_v[g], result_v[g],
          add_a_v[g], add_b_v[g]}, 32'd0);
    end
    rst = 1'b0;

    run_op("add_7_5",   2'b00, 4'd7,  4'd5,  8'h0C, 1'b0, 2, 3, 4,  1'b0);
    run_op("add_15_15", 2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 2, 3, 4,  1'b0);
    run_op("sub_1_1",   2'b01, 4'd1,  4'd1,  8'h00, 1'b0, 2, 3, 4,  1'b0);
    run_op("sub_0_1",   2'b01, 4'd0,  4'd1,  8'h0F, 1'b1, 2, 3, 4,  1'b0);
    run_op("mul_15_15", 2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 5, 9, 13, 1'b0);
    run_op("mul_0_9",   2'b10, 4'd0,  4'd9,  8'h00, 1'b0, 5, 9, 13, 1'b0);
    run_op("mul_poked", 2'b10, 4'd6,  4'd7,  8'h2A, 1'b0, 5, 9, 13, 1'b1);
    run_op("reserved",  2'b11, 4'd3,  4'd3,  8'h00, 1'b1, 2, 2, 2,  1'b0);
    run_op("mul_13_11", 2'b10, 4'd13, 4'd11, 8'h8F, 1'b0, 5, 9, 13, 1'b0);

    // Start held high: re-accepted each time the done cycle comes round.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; opa = 4'd9; opb = 4'd3;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("held_start_result", g, 32'(result_v[g]), 32'h06);

    // Abort a multiply mid-way.
    run_op("mul_9_9", 2'b10, 4'd9, 4'd9, 8'h51, 1'b0, 5, 9, 13, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; opa = 4'd15; opb = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("abort_state", g, {busy_v[g], done_v[g], ovf_v[g], add_cin_v[g], result_v[g],
          add_a_v[g], add_b_v[g]}, 32'd0);
    end
    repeat (15) @(posedge clk);
    run_op("add_3_4", 2'b00, 4'd3, 4'd4, 8'h07, 1'b0, 2, 3, 4, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
